// File: rtl/memory_controller_pkg.sv
// memory_controller_pkg: state codes, access-size encodings and IO window base
package memory_controller_pkg;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } mc_state_t;

    // Size encodings double as byte counts (1, 2, 4)
    localparam logic [2:0] SIZE_B = 3'b001;
    localparam logic [2:0] SIZE_H = 3'b010;
    localparam logic [2:0] SIZE_W = 3'b100;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

endpackage

// File: rtl/memory_controller_if.sv
// memory_controller_if: LSB, fetch and byte-wide RAM/IO bus signals
interface memory_controller_if;

    logic        lsb_enable;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_data;
    logic [2:0]  lsb_size;
    logic        lsb_is_load;
    logic        lsb_sign_ext;
    logic        mem_valid;
    logic [31:0] mem_res;
    logic        if_enable;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    modport slave (
        input  lsb_enable, lsb_addr, lsb_data, lsb_size, lsb_is_load, lsb_sign_ext,
        input  if_enable, if_addr, mem_din, io_buffer_full,
        output mem_valid, mem_res, if_valid, if_inst, mem_dout, mem_a, mem_wr
    );

    modport master (
        output lsb_enable, lsb_addr, lsb_data, lsb_size, lsb_is_load, lsb_sign_ext,
        output if_enable, if_addr, mem_din, io_buffer_full,
        input  mem_valid, mem_res, if_valid, if_inst, mem_dout, mem_a, mem_wr
    );

endinterface

// File: rtl/memory_controller.sv
// memory_controller: arbitrates LSB/fetch requests and serialises them into byte RAM/IO transfers
module memory_controller
    import memory_controller_pkg::*;
#(
    parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    input  logic wrong_commit,
    memory_controller_if.slave bus
);

    mc_state_t   r_state, w_state;
    logic [2:0]  r_cnt, w_cnt;
    logic [2:0]  r_size, w_size;
    logic [31:0] r_data, w_data;
    logic        r_fetch, w_fetch;
    logic        r_store, w_store;
    logic        r_sext, w_sext;
    logic [31:0] r_buf, w_buf;
    logic [31:0] r_mem_res, w_mem_res;
    logic [31:0] r_if_inst, w_if_inst;
    logic [31:0] r_mem_a, w_mem_a;
    logic [7:0]  r_mem_dout, w_mem_dout;
    logic        r_wr, w_wr;
    logic [31:0] w_fill;
    logic [1:0]  w_idx, w_nidx;
    logic        w_stall;

    function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [2:0] size, input logic sext);
        return (size == SIZE_B) ? {{24{sext & raw[7]}}, raw[7:0]} :
               (size == SIZE_H) ? {{16{sext & raw[15]}}, raw[15:0]} : raw;
    endfunction

    // Read data lags the address by a cycle, so counter k receives byte k-1
    assign w_idx   = r_cnt[1:0] - 2'd1;
    assign w_nidx  = r_cnt[1:0] + 2'd1;
    assign w_stall = r_wr & (r_mem_a >= IO_BASE) & bus.io_buffer_full;

    assign bus.mem_valid = (r_state == MC_DONE) & ~r_fetch;
    assign bus.if_valid  = (r_state == MC_DONE) & r_fetch;
    assign bus.mem_res   = r_mem_res;
    assign bus.if_inst   = r_if_inst;
    assign bus.mem_a     = r_mem_a;
    assign bus.mem_dout  = r_mem_dout;
    assign bus.mem_wr    = r_wr & ~w_stall;

    // Next-state and datapath: accept in IDLE, step bytes in BUSY, pulse in DONE
    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_size     = r_size;
        w_data     = r_data;
        w_fetch    = r_fetch;
        w_store    = r_store;
        w_sext     = r_sext;
        w_buf      = r_buf;
        w_mem_res  = r_mem_res;
        w_if_inst  = r_if_inst;
        w_mem_a    = r_mem_a;
        w_mem_dout = r_mem_dout;
        w_wr       = r_wr;
        w_fill     = r_buf;
        w_fill[{w_idx, 3'b000} +: 8] = bus.mem_din;
        case (r_state)
            MC_IDLE: begin
                if (!wrong_commit && (bus.lsb_enable || bus.if_enable)) begin
                    w_state    = MC_BUSY;
                    w_cnt      = 3'd0;
                    w_buf      = 32'd0;
                    w_fetch    = ~bus.lsb_enable;
                    w_store    = bus.lsb_enable & ~bus.lsb_is_load;
                    w_size     = bus.lsb_enable ? bus.lsb_size : SIZE_W;
                    w_sext     = bus.lsb_sign_ext;
                    w_data     = bus.lsb_data;
                    w_mem_a    = bus.lsb_enable ? bus.lsb_addr : bus.if_addr;
                    w_mem_dout = w_store ? bus.lsb_data[7:0] : r_mem_dout;
                    w_wr       = w_store;
                end
            end
            MC_BUSY: begin
                if (r_store) begin
                    if (!w_stall) begin
                        if (r_cnt == r_size - 3'd1) begin
                            w_state   = MC_DONE;
                            w_wr      = 1'b0;
                            w_mem_res = 32'd0;
                        end else begin
                            w_cnt      = r_cnt + 3'd1;
                            w_mem_a    = r_mem_a + 32'd1;
                            w_mem_dout = r_data[{w_nidx, 3'b000} +: 8];
                        end
                    end
                end else if (wrong_commit) begin
                    w_state = MC_IDLE;
                end else begin
                    if (r_cnt != 3'd0) w_buf = w_fill;
                    if (r_cnt == r_size) begin
                        w_state = MC_DONE;
                        if (r_fetch) w_if_inst = w_fill;
                        else w_mem_res = extend_load(w_fill, r_size, r_sext);
                    end else begin
                        w_cnt   = r_cnt + 3'd1;
                        w_mem_a = r_mem_a + 32'd1;
                    end
                end
            end
            default: w_state = MC_IDLE;
        endcase
    end

    // State and output registers; rdy low freezes everything
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= MC_IDLE;
            r_cnt      <= 3'd0;
            r_size     <= 3'd0;
            r_data     <= 32'd0;
            r_fetch    <= 1'b0;
            r_store    <= 1'b0;
            r_sext     <= 1'b0;
            r_buf      <= 32'd0;
            r_mem_res  <= 32'd0;
            r_if_inst  <= 32'd0;
            r_mem_a    <= 32'd0;
            r_mem_dout <= 8'd0;
            r_wr       <= 1'b0;
        end else if (rdy) begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_size     <= w_size;
            r_data     <= w_data;
            r_fetch    <= w_fetch;
            r_store    <= w_store;
            r_sext     <= w_sext;
            r_buf      <= w_buf;
            r_mem_res  <= w_mem_res;
            r_if_inst  <= w_if_inst;
            r_mem_a    <= w_mem_a;
            r_mem_dout <= w_mem_dout;
            r_wr       <= w_wr;
        end
    end

endmodule

// File: tb/tb_memory_controller.sv
// tb_memory_controller: directed vectors against a byte-array memory model and latency rules
module tb_memory_controller;
    import memory_controller_pkg::*;

    localparam logic [31:0] IO_BASE = 32'h0003_0000;

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    logic clk = 1'b0;
    logic rst, rdy, wc;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   chk_on = 1'b0;

    int          exp_mem_cyc = -1;
    logic [31:0] exp_mem_res = 32'd0;
    int          exp_if_cyc = -1;
    logic [31:0] exp_if_inst = 32'd0;
    wr_t         wq[$];
    wr_t         e;
    logic [7:0]  ram [0:4095];

    memory_controller_if bus();

    memory_controller #(.IO_BASE(IO_BASE)) dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
        .wrong_commit(wc),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte RAM: one-cycle read latency; IO-window writes are not stored
    always @(posedge clk) begin
        bus.mem_din <= ram[bus.mem_a[11:0]];
        if (bus.mem_wr === 1'b1 && bus.mem_a < IO_BASE) ram[bus.mem_a[11:0]] = bus.mem_dout;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Value of an n-byte little-endian load, built by weighted byte sums
    function automatic logic [31:0] model_load(input logic [31:0] a, input int n, input bit sx);
        int v, span;
        v = 0;
        span = 1;
        for (int k = 0; k < n; k++) begin
            v += int'(ram[12'(a + 32'(k))]) * span;
            span *= 256;
        end
        if (sx && n < 4 && v >= span / 2) v -= span;
        return 32'(v);
    endfunction

    // Per-cycle comparison of valid pulses, results and write traffic
    always @(negedge clk) begin
        if (chk_on) begin
            check("mem_valid", {31'd0, bus.mem_valid}, {31'd0, cyc == exp_mem_cyc});
            check("if_valid", {31'd0, bus.if_valid}, {31'd0, cyc == exp_if_cyc});
            if (cyc == exp_mem_cyc) check("mem_res", bus.mem_res, exp_mem_res);
            if (cyc == exp_if_cyc) check("if_inst", bus.if_inst, exp_if_inst);
            if (bus.mem_wr !== 1'b0) begin
                if (wq.size() == 0) begin
                    check("wr_unexpected", {31'd0, bus.mem_wr}, 32'd0);
                end else begin
                    e = wq.pop_front();
                    check("wr_addr", bus.mem_a, e.a);
                    check("wr_data", {24'd0, bus.mem_dout}, {24'd0, e.d});
                    check("wr_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lsb_issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz, input bit ld, input bit sx);
        bus.lsb_addr     = a;
        bus.lsb_data     = d;
        bus.lsb_size     = sz;
        bus.lsb_is_load  = ld;
        bus.lsb_sign_ext = sx;
        bus.lsb_enable   = 1'b1;
    endtask

    task automatic lsb_finish(input string nm, input logic [31:0] lit);
        while (cyc < exp_mem_cyc) tick();
        @(negedge clk);
        check(nm, bus.mem_res, lit);
        tick();
        bus.lsb_enable = 1'b0;
    endtask

    task automatic lsb_op(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz, input bit ld, input bit sx,
                          input int stall, input int wc_at, input logic [31:0] lit, input string nm);
        int t, n;
        t = cyc;
        n = int'(sz);
        lsb_issue(a, d, sz, ld, sx);
        if (ld) begin
            exp_mem_res = model_load(a, n, sx);
            exp_mem_cyc = t + n + 2;
        end else begin
            exp_mem_res = 32'd0;
            exp_mem_cyc = t + n + 1 + stall;
            for (int k = 0; k < n; k++) wq.push_back('{t + 1 + k + stall, a + 32'(k), d[8*k +: 8]});
        end
        if (stall > 0) begin
            bus.io_buffer_full = 1'b1;
            repeat (stall + 1) tick();
            bus.io_buffer_full = 1'b0;
        end
        while (cyc < exp_mem_cyc) begin
            tick();
            wc = (wc_at > 0 && cyc == t + wc_at);
        end
        wc = 1'b0;
        lsb_finish(nm, lit);
        check({nm, "_writes_left"}, 32'(wq.size()), 32'd0);
    endtask

    task automatic fetch_finish(input string nm, input logic [31:0] lit);
        while (cyc < exp_if_cyc) tick();
        @(negedge clk);
        check(nm, bus.if_inst, lit);
        tick();
        bus.if_enable = 1'b0;
    endtask

    initial begin
        int t;
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
        ram[12'h110] = 8'h80;
        ram[12'h120] = 8'h34; ram[12'h121] = 8'h92;
        ram[12'h000] = 8'h93; ram[12'h001] = 8'h00; ram[12'h002] = 8'h10; ram[12'h003] = 8'h00;
        ram[12'hFFE] = 8'hAA; ram[12'hFFF] = 8'hBB;
        rst = 1'b1; rdy = 1'b1; wc = 1'b0;
        bus.lsb_enable = 1'b0; bus.lsb_addr = 32'd0; bus.lsb_data = 32'd0; bus.lsb_size = SIZE_W;
        bus.lsb_is_load = 1'b1; bus.lsb_sign_ext = 1'b0;
        bus.if_enable = 1'b0; bus.if_addr = 32'd0; bus.io_buffer_full = 1'b0;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
        check("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
        check("rst_mem_res", bus.mem_res, 32'd0);
        check("rst_if_inst", bus.if_inst, 32'd0);
        check("rst_mem_a", bus.mem_a, 32'd0);
        check("rst_mem_dout", {24'd0, bus.mem_dout}, 32'd0);
        check("rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
        chk_on = 1'b1;
        tick();

        lsb_op(32'h100, 32'd0, SIZE_W, 1, 0, 0, 0, 32'h44332211, "lw_100");
        lsb_op(32'h110, 32'd0, SIZE_B, 1, 1, 0, 0, 32'hFFFFFF80, "lb_sext");
        lsb_op(32'h110, 32'd0, SIZE_B, 1, 0, 0, 0, 32'h00000080, "lbu");
        lsb_op(32'h120, 32'd0, SIZE_H, 1, 1, 0, 0, 32'hFFFF9234, "lh_sext");
        lsb_op(32'h200, 32'hABCD1234, SIZE_H, 0, 0, 0, 0, 32'd0, "sh_200");
        lsb_op(32'h200, 32'd0, SIZE_W, 1, 0, 0, 0, 32'h00001234, "lw_after_sh");

        // LSB and fetch raised together: LSB first, fetch starts in the IDLE after DONE
        t = cyc;
        lsb_issue(32'h120, 32'd0, SIZE_H, 1, 1);
        bus.if_addr = 32'h0;
        bus.if_enable = 1'b1;
        exp_mem_res = model_load(32'h120, 2, 1);
        exp_mem_cyc = t + 4;
        exp_if_inst = model_load(32'h0, 4, 0);
        exp_if_cyc  = t + 5 + 6;
        lsb_finish("arb_lsb_first", 32'hFFFF9234);
        fetch_finish("arb_fetch", 32'h00100093);

        lsb_op(IO_BASE, 32'h0000005A, SIZE_B, 0, 0, 3, 0, 32'd0, "sb_io_stall");

        // Flush while byte 2 of a fetch is on the bus: no pulse, back to IDLE
        t = cyc;
        bus.if_addr = 32'h0;
        bus.if_enable = 1'b1;
        exp_if_cyc = -1;
        repeat (3) tick();
        wc = 1'b1;
        bus.if_enable = 1'b0;
        tick();
        wc = 1'b0;
        repeat (8) tick();
        t = cyc;
        bus.if_addr = 32'h100;
        bus.if_enable = 1'b1;
        exp_if_inst = model_load(32'h100, 4, 0);
        exp_if_cyc = t + 6;
        fetch_finish("fetch_after_flush", 32'h44332211);

        lsb_op(32'h300, 32'hDEADBEEF, SIZE_W, 0, 0, 0, 2, 32'd0, "sw_flush");
        lsb_op(32'h300, 32'd0, SIZE_W, 1, 0, 0, 0, 32'hDEADBEEF, "lw_after_sw");

        // wrong_commit in IDLE delays acceptance by one cycle
        t = cyc;
        wc = 1'b1;
        lsb_issue(32'h110, 32'd0, SIZE_B, 1, 0);
        exp_mem_res = model_load(32'h110, 1, 0);
        exp_mem_cyc = t + 1 + 3;
        tick();
        wc = 1'b0;
        lsb_finish("wc_idle_lbu", 32'h00000080);

        // rdy low for two cycles in IDLE delays acceptance by two cycles
        t = cyc;
        rdy = 1'b0;
        lsb_issue(32'h100, 32'd0, SIZE_W, 1, 0);
        exp_mem_res = model_load(32'h100, 4, 0);
        exp_mem_cyc = t + 2 + 6;
        tick(); tick();
        rdy = 1'b1;
        lsb_finish("rdy_low_lw", 32'h44332211);

        lsb_op(32'hFFFF_FFFE, 32'd0, SIZE_H, 1, 0, 0, 0, 32'h0000BBAA, "lhu_wrap");

        // Reset in the middle of a load clears every output
        lsb_issue(32'h100, 32'd0, SIZE_W, 1, 0);
        exp_mem_cyc = -1;
        repeat (3) tick();
        rst = 1'b1;
        bus.lsb_enable = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
        check("mid_rst_mem_res", bus.mem_res, 32'd0);
        check("mid_rst_if_inst", bus.if_inst, 32'd0);
        check("mid_rst_mem_a", bus.mem_a, 32'd0);
        check("mid_rst_mem_dout", {24'd0, bus.mem_dout}, 32'd0);
        check("mid_rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
        repeat (4) tick();
        check("final_writes_left", 32'(wq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/memory_controller.md
Name: memory_controller

Overview:
Responder side of the load/store request interface driven by the load-store buffer, and also of the instruction-fetch request interface. Arbitrates between one data requester (LSB) and one instruction requester (fetch). Serialises each 1/2/4-byte access into byte-wide transfers on the single-port RAM/IO bus. Returns one result pulse per completed request; load data is sign- or zero-extended to 32 bits.

Parameters:
IO_BASE, 32'h00030000, addresses >= IO_BASE are IO; byte writes there are gated by io_buffer_full.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; low = freeze all state
wrong_commit  in  1  pipeline flush from ROB
lsb_enable  in  1  LSB request, held high until mem_valid
lsb_addr  in  32  byte address
lsb_data  in  32  store data, little-endian
lsb_size  in  3  3'b001 byte, 3'b010 half, 3'b100 word
lsb_is_load  in  1  1 = load, 0 = store
lsb_sign_ext  in  1  1 = sign-extend load result (LB/LH)
mem_valid  out  1  one-cycle completion pulse to LSB
mem_res  out  32  load result (0 for stores)
if_enable  in  1  fetch request, held until if_valid
if_addr  in  32  fetch PC
if_valid  out  1  one-cycle completion pulse to fetch
if_inst  out  32  fetched word
mem_din  in  8  RAM read byte
mem_dout  out  8  RAM write byte
mem_a  out  32  RAM address
mem_wr  out  1  1 = write
io_buffer_full  in  1  IO write back-pressure

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset: state IDLE; mem_valid, mem_res, if_valid, if_inst, mem_dout, mem_a, mem_wr all 0; byte counter 0.
- rdy = 0: no state, counter or output register changes.
- States:
  - IDLE: accept a request; LSB has priority over fetch when both are high.
  - BUSY: transfer bytes 0..N-1; N = 1, 2 or 4 (fetch is always 4).
  - DONE: exactly one cycle; the valid pulse is high here.
  - DONE always returns to IDLE. Requests are ignored in DONE because the requester drops enable on the edge that sees valid.
- No preemption once BUSY.
- Byte k uses address base+k. Store byte k = data[8k+7:8k]. Load byte k fills res[8k+7:8k].
- RAM read data appears on mem_din the cycle after its address is driven.
- Load/fetch latency: request first high in IDLE cycle T -> valid high in cycle T+N+2.
- Store latency: valid in cycle T+N+1.
- mem_wr is high only in cycles driving a store byte; otherwise mem_wr = 0.
- Load extension:
  - size 1: res[31:8] = sign_ext ? {24{b0[7]}} : 0.
  - size 2: res[31:16] = sign_ext ? {16{b1[7]}} : 0.
- IO stores: if addr >= IO_BASE and io_buffer_full = 1, the controller holds the current byte (mem_wr = 0, counter frozen) until io_buffer_full = 0. This adds the stall cycles to the latency.
- wrong_commit:
  - Active fetch or load: abort to IDLE next cycle, mem_wr = 0, no valid pulse.
  - Active store: the store is already committed and completes normally.
  - wrong_commit in IDLE: nothing is accepted that cycle.
- Outputs are held between transactions: if_inst/mem_res keep the last value; valid flags are 0 outside DONE.
- Address arithmetic wraps mod 2^32.

Decomposition:
- const_def.v gains:
  - MC_IDLE/MC_BUSY/MC_DONE state codes (2-bit).
  - SIZE_B/SIZE_H/SIZE_W encodings.
  - IO_BASE default.
- Single module; no sub-module. Load extension is a local function.

Test Plan:
- LW addr 0x100, RAM bytes 0x11,0x22,0x33,0x44 -> mem_res = 0x44332211, mem_valid high in cycle T+6, one cycle only.
- LB, sign_ext = 1, byte 0x80 -> 0xFFFFFF80. LBU (sign_ext = 0) same address -> 0x00000080. LH with bytes 0x34,0x92 -> 0xFFFF9234.
- SH addr 0x200, data 0xABCD1234 -> mem_wr = 1 with (0x200, 0x34) then (0x201, 0x12); mem_valid at T+3; no further writes.
- Fetch 0x0 and LSB load raised in the same cycle -> LSB served first. Fetch then completes with if_inst = RAM word at 0x0. Exactly one pulse each.
- SB to 0x30000 with io_buffer_full high for 3 cycles -> write occurs on the first cycle it is low; mem_valid is delayed 3 cycles.
- wrong_commit during byte 2 of a fetch -> IDLE, no if_valid. The same flush during an SW -> all 4 bytes written, mem_valid pulses. Asserting rst mid-transaction clears all outputs next cycle.
